// File: rtl/mac_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mac_tx_arbiter
// Purpose  : Round-robin arbiter that shares one MAC transmit byte stream
//            between NUM_REQ frame sources, with IFG insertion and truncation.
// Revision : 1.0 - initial release
// ============================================================================
module mac_tx_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int IFG_CYCLES = 12,
    parameter int MAX_FRAME  = 1500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    output logic [NUM_REQ-1:0]      grant,
    input  logic [NUM_REQ*8-1:0]    in_data,
    input  logic [NUM_REQ-1:0]      in_valid,
    input  logic [NUM_REQ-1:0]      in_last,
    output logic [NUM_REQ-1:0]      in_ready,
    input  logic [NUM_REQ*48-1:0]   in_dst,
    input  logic [NUM_REQ*16-1:0]   in_type,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    output logic                    tx_last,
    input  logic                    tx_ready,
    output logic [47:0]             tx_dst,
    output logic [15:0]             tx_type,
    output logic                    busy,
    output logic                    overflow_err
);

    localparam int c_IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_XFER  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_IFG   = 2'd3;

    localparam logic [15:0]        c_MAX_M1 = 16'(MAX_FRAME - 1);
    localparam logic [15:0]        c_IFG_M1 = 16'(IFG_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] c_ONE    = NUM_REQ'(1);

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [c_IDXW-1:0]  r_gidx;
    logic [c_IDXW-1:0]  r_last_grant;
    logic [15:0]        r_cnt;
    logic               r_ovf;
    logic [47:0]        r_dst;
    logic [15:0]        r_type;

    logic               w_found;
    logic [c_IDXW-1:0]  w_win;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic [7:0]         w_sel_data;
    logic               w_at_max;
    logic               w_accept;
    logic               w_drain_last;

    // Search upward from the requester after the previous winner, wrapping.
    always_comb begin
        int j;
        w_found = 1'b0;
        w_win   = r_last_grant;
        j       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(r_last_grant) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                w_win   = j[c_IDXW-1:0];
            end
        end
    end

    assign w_sel_valid  = in_valid[r_gidx];
    assign w_sel_last   = in_last[r_gidx];
    assign w_sel_data   = in_data[int'(r_gidx)*8 +: 8];
    assign w_at_max     = (r_cnt == c_MAX_M1);
    assign w_accept     = (r_state == c_XFER) && w_sel_valid && tx_ready;
    assign w_drain_last = (r_state == c_DRAIN) && w_sel_valid && w_sel_last;

    // Byte path is a pure passthrough of the grantee; DRAIN swallows bytes.
    always_comb begin
        tx_data  = 8'd0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        in_ready = '0;
        if (r_state == c_XFER) begin
            tx_data          = w_sel_data;
            tx_valid         = w_sel_valid;
            tx_last          = w_sel_last | w_at_max;
            in_ready[r_gidx] = tx_ready;
        end else if (r_state == c_DRAIN) begin
            in_ready[r_gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_last_grant <= c_IDXW'(NUM_REQ - 1);
            r_cnt        <= 16'd0;
            r_ovf        <= 1'b0;
            r_dst        <= 48'd0;
            r_type       <= 16'd0;
        end else begin
            r_ovf <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_state      <= c_XFER;
                        r_grant      <= c_ONE << w_win;
                        r_gidx       <= w_win;
                        r_last_grant <= w_win;
                        r_dst        <= in_dst[int'(w_win)*48 +: 48];
                        r_type       <= in_type[int'(w_win)*16 +: 16];
                        r_cnt        <= 16'd0;
                    end
                end
                c_XFER: begin
                    if (w_accept) begin
                        if (w_sel_last) begin
                            r_state <= c_IFG;
                            r_grant <= '0;
                            r_cnt   <= 16'd0;
                        end else if (w_at_max) begin
                            r_state <= c_DRAIN;
                            r_ovf   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                c_DRAIN: begin
                    if (w_drain_last) begin
                        r_state <= c_IFG;
                        r_grant <= '0;
                        r_cnt   <= 16'd0;
                    end
                end
                c_IFG: begin
                    if (r_cnt >= c_IFG_M1) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign grant        = r_grant;
    assign busy         = (r_state != c_IDLE);
    assign overflow_err = r_ovf;
    assign tx_dst       = r_dst;
    assign tx_type      = r_type;

endmodule
`default_nettype wire

// File: tb/tb_mac_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_tx_arbiter
// Purpose  : Randomized scoreboard bench for mac_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_tx_arbiter;

    localparam int N    = 2;
    localparam int IFG  = 12;
    localparam int MAXF = 16;

    typedef struct {
        int          len;
        int          seed;
        logic [47:0] dst;
        logic [15:0] typ;
        bit          drop;
        bit          gaps;
    } frame_t;

    typedef struct {
        logic [7:0]  d;
        bit          last;
        bit          trunc;
        logic [47:0] dst;
        logic [15:0] typ;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N-1:0]      grant;
    logic [N*8-1:0]    in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_last;
    logic [N-1:0]      in_ready;
    logic [N*48-1:0]   in_dst;
    logic [N*16-1:0]   in_type;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_last;
    logic              tx_ready;
    logic [47:0]       tx_dst;
    logic [15:0]       tx_type;
    logic              busy;
    logic              overflow_err;

    always #5 clk = ~clk;

    mac_tx_arbiter #(
        .NUM_REQ    (N),
        .IFG_CYCLES (IFG),
        .MAX_FRAME  (MAXF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant        (grant),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .in_dst       (in_dst),
        .in_type      (in_type),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_last      (tx_last),
        .tx_ready     (tx_ready),
        .tx_dst       (tx_dst),
        .tx_type      (tx_type),
        .busy         (busy),
        .overflow_err (overflow_err)
    );

    frame_t pend_q [N][$];
    exp_t   exp_q  [N][$];
    int     checks = 0;
    int     errors = 0;
    int     rmode  = 0;
    bit     [N-1:0] acc = '0;
    frame_t cur    [N];
    bit     active [N];
    int     idx    [N];

    // monitor-owned tracking
    int           cur_g     = -1;
    int           fwd_cnt   = 0;
    bit           drain     = 0;
    bit           drop_pend = 0;
    bit           exp_ovf   = 0;
    bit           idle_req  = 0;
    int           zero_cnt  = 1000;
    int           ifg_cnt   = 0;
    int           rr_ptr    = N - 1;
    logic [N-1:0] prev_req  = '0;
    logic [N-1:0] prev_grant = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] byte_of(input int seed, input int k);
        return 8'(seed + k * 53 + (k >> 2));
    endfunction

    // Frame content is fixed at issue time; the reference forwards the first
    // min(len, MAXF) bytes, marks the final forwarded one last, and flags
    // truncation when the frame was longer than MAXF.
    task automatic issue(input int r, input int len, input bit drop, input bit gaps);
        frame_t      f;
        exp_t        e;
        logic [63:0] t;
        int          n;
        t      = {$urandom, $urandom};
        f.len  = len;
        f.seed = int'($urandom);
        f.dst  = t[47:0];
        f.typ  = 16'($urandom);
        f.drop = drop;
        f.gaps = gaps;
        n = (len < MAXF) ? len : MAXF;
        for (int k = 0; k < n; k++) begin
            e.d     = byte_of(f.seed, k);
            e.last  = (k == n - 1);
            e.trunc = (len > MAXF) && (k == n - 1);
            e.dst   = f.dst;
            e.typ   = f.typ;
            exp_q[r].push_back(e);
        end
        pend_q[r].push_back(f);
    endtask

    // requester and encoder-side driver
    initial begin
        req      = '0;
        in_valid = '0;
        in_last  = '0;
        in_data  = '0;
        in_dst   = '0;
        in_type  = '0;
        tx_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            active[i] = 0;
            idx[i]    = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    active[i]   = 0;
                    req[i]      = 1'b0;
                    in_valid[i] = 1'b0;
                    in_last[i]  = 1'b0;
                    pend_q[i].delete();
                    continue;
                end
                if (active[i] && acc[i]) begin
                    if (idx[i] == cur[i].len - 1) begin
                        active[i] = 0;
                        req[i]    = 1'b0;
                    end
                    idx[i]++;
                end
                if (!active[i] && pend_q[i].size() > 0) begin
                    cur[i]    = pend_q[i].pop_front();
                    active[i] = 1;
                    idx[i]    = 0;
                    req[i]    = 1'b1;
                    in_dst[i*48 +: 48]  = cur[i].dst;
                    in_type[i*16 +: 16] = cur[i].typ;
                end
                if (active[i] && cur[i].drop && grant[i]) begin
                    req[i] = 1'b0;
                end
                if (active[i]) begin
                    in_valid[i]       = !cur[i].gaps || ($urandom_range(3) != 0);
                    in_data[i*8 +: 8] = byte_of(cur[i].seed, idx[i]);
                    in_last[i]        = (idx[i] == cur[i].len - 1);
                end else begin
                    in_valid[i] = 1'b0;
                    in_last[i]  = 1'b0;
                end
            end
            case (rmode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = ($urandom_range(2) != 0);
            endcase
        end
    end

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            acc = in_valid & in_ready;
            if (rst) begin
                for (int i = 0; i < N; i++) exp_q[i].delete();
                cur_g = -1; fwd_cnt = 0; drain = 0; drop_pend = 0; exp_ovf = 0;
                idle_req = 0; zero_cnt = 1000; ifg_cnt = 0; rr_ptr = N - 1;
                prev_req = req; prev_grant = '0;
                continue;
            end
            chk("overflow_pulse", 64'(overflow_err), 64'(exp_ovf));
            exp_ovf = 0;
            if (idle_req) chk("grant_latency", 64'(grant != 0), 64'(1));
            idle_req = 0;
            if (drop_pend) begin
                chk("grant_release", 64'(grant), 64'(0));
                drop_pend = 0;
                cur_g     = -1;
                drain     = 0;
            end
            if (grant != 0 && prev_grant == 0) begin
                int w;
                int expw;
                w    = -1;
                expw = -1;
                for (int k = 0; k < N; k++) if (grant[k]) w = k;
                for (int k = 1; k <= N; k++) begin
                    if (expw < 0 && prev_req[(rr_ptr + k) % N]) expw = (rr_ptr + k) % N;
                end
                chk("grant_onehot", 64'($countones(grant)), 64'(1));
                chk("rr_winner", 64'(w), 64'(expw));
                chk("grant_gap", 64'(zero_cnt >= IFG + 1), 64'(1));
                chk("busy_with_grant", 64'(busy), 64'(1));
                rr_ptr  = w;
                cur_g   = w;
                drain   = 0;
                fwd_cnt = 0;
            end
            if (grant == 0) zero_cnt++;
            else            zero_cnt = 0;

            if (cur_g >= 0 && grant != 0) begin
                if (!drain) begin
                    logic [N-1:0] er;
                    er        = '0;
                    er[cur_g] = tx_ready;
                    chk("in_ready_pass", 64'(in_ready), 64'(er));
                    chk("tx_valid_pass", 64'(tx_valid), 64'(in_valid[cur_g]));
                    if (tx_valid && tx_ready) begin
                        if (exp_q[cur_g].size() == 0) begin
                            chk("unexpected_beat", 64'(1), 64'(0));
                        end else begin
                            exp_t e;
                            e = exp_q[cur_g].pop_front();
                            chk("tx_data",  64'(tx_data), 64'(e.d));
                            chk("tx_last",  64'(tx_last), 64'(e.last));
                            chk("tx_dst",   64'(tx_dst),  64'(e.dst));
                            chk("tx_type",  64'(tx_type), 64'(e.typ));
                            fwd_cnt++;
                            if (e.last) begin
                                if (e.trunc) begin
                                    exp_ovf = 1;
                                    drain   = 1;
                                end else begin
                                    drop_pend = 1;
                                end
                            end
                        end
                    end
                end else begin
                    chk("drain_tx_valid", 64'(tx_valid), 64'(0));
                    chk("drain_in_ready", 64'(in_ready[cur_g]), 64'(1));
                    if (in_valid[cur_g] && in_last[cur_g]) drop_pend = 1;
                end
            end
            if (grant == 0) begin
                chk("idle_quiet", 64'({tx_valid, |in_ready}), 64'(0));
            end
            if (busy && grant == 0) begin
                ifg_cnt++;
            end else if (!busy) begin
                if (ifg_cnt > 0) chk("ifg_length", 64'(ifg_cnt), 64'(IFG));
                ifg_cnt = 0;
            end
            idle_req   = (!busy && req != 0);
            prev_req   = req;
            prev_grant = grant;
        end
    end

    task automatic wait_idle(input int limit);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        while (n < limit && !done) begin
            @(posedge clk);
            n++;
            done = !busy && req == 0;
            for (int i = 0; i < N; i++) begin
                if (active[i] || pend_q[i].size() != 0 || exp_q[i].size() != 0) done = 0;
            end
        end
        chk("idle_timeout", 64'(n >= limit), 64'(0));
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_values();
        chk("rst_grant",    64'(grant),        64'(0));
        chk("rst_tx_valid", 64'(tx_valid),     64'(0));
        chk("rst_tx_last",  64'(tx_last),      64'(0));
        chk("rst_busy",     64'(busy),         64'(0));
        chk("rst_overflow", 64'(overflow_err), 64'(0));
        chk("rst_tx_dst",   64'(tx_dst),       64'(0));
        chk("rst_tx_type",  64'(tx_type),      64'(0));
        chk("rst_in_ready", 64'(in_ready),     64'(0));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // single request, then both requesters contending
        issue(0, 10, 0, 0);
        wait_idle(2000);
        issue(0, 10, 0, 0); issue(1, 10, 0, 0);
        issue(0, 10, 0, 0); issue(1, 10, 0, 0);
        wait_idle(2000);

        // backpressure
        rmode = 1;
        issue(1, 14, 0, 0);
        wait_idle(2000);
        rmode = 0;

        // oversize, exact-limit and one-over frames
        issue(0, 24, 0, 0);
        issue(1, MAXF, 0, 0);
        issue(0, MAXF + 1, 0, 1);
        wait_idle(2000);

        // request withdrawn right after grant
        issue(1, 12, 1, 0);
        wait_idle(2000);

        // randomized traffic
        for (int f = 0; f < 40; f++) begin
            rmode = $urandom_range(2);
            issue($urandom_range(1), $urandom_range(24, 1), 1'($urandom_range(1)), 1'($urandom_range(1)));
            if ($urandom_range(3) == 0) repeat ($urandom_range(40)) @(posedge clk);
        end
        wait_idle(30000);
        rmode = 0;

        // reset in the middle of a frame from requester 0
        issue(0, 12, 0, 0);
        n = 0;
        while (n < 500 && !(cur_g == 0 && fwd_cnt >= 5)) begin
            @(negedge clk);
            n++;
        end
        chk("midframe_wait_timeout", 64'(n >= 500), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        issue(0, 8, 0, 0);
        issue(1, 8, 0, 0);
        wait_idle(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
